int_to_float: RTL and testbench



---
 rtl/int_to_float_pkg.sv | 26 ++
 rtl/data_mem.sv | 25 ++
 rtl/int_to_float.sv | 199 +++++++++++++++++++
 tb/tb_int_to_float.sv | 120 ++++++++++++
 4 files changed

// File: rtl/int_to_float_pkg.sv
// Shared types and constants for the int16 -> half-precision converter.
package int_to_float_pkg;

    // Conversion sequencer states
    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        LD_LO = 4'd1,
        LD_HI = 4'd2,
        NEG   = 4'd3,
        NORM  = 4'd4,
        ROUND = 4'd5,
        ST_LO = 4'd6,
        ST_HI = 4'd7,
        DONE  = 4'd8
    } state_t;

    // IEEE-754 binary16 exponent bias
    localparam int BIAS = 15;

    // Fixed operand / result byte locations in the data memory
    localparam int ADDR_IN_LO  = 0;
    localparam int ADDR_IN_HI  = 1;
    localparam int ADDR_OUT_LO = 2;
    localparam int ADDR_OUT_HI = 3;

endpackage

// File: rtl/data_mem.sv
// Byte-wide local data memory: asynchronous read, synchronous write.
// The storage array is named core so it can be preloaded hierarchically.
module data_mem #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] core [DEPTH];

    // Synchronous byte write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            core[addr] <= wdata;
        end
    end

    assign rdata = core[addr];

endmodule

// File: rtl/int_to_float.sv
// Start/done engine converting a 16-bit two's-complement integer stored in
// bytes 0..1 of the local memory into a binary16 float written to bytes 2..3,
// with round-to-nearest-even. Normalisation shifts one bit per cycle.
module int_to_float
    import int_to_float_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int BIAS      = int_to_float_pkg::BIAS
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);

    localparam int ADDR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // Exponent of a value whose leading one sits at bit 14
    localparam logic [4:0] EXP_TOP = 5'(BIAS + 14);
    // Result for the most negative input: sign 1, exponent BIAS+15, mantissa 0
    localparam logic [15:0] MIN_INT_WORD = {1'b1, 5'(BIAS + 15), 10'd0};

    state_t      state_r;
    state_t      state_nxt_s;
    logic        start_d_r;
    logic        done_r;
    logic [15:0] operand_r;
    logic        sign_r;
    logic [14:0] mag_r;
    logic [4:0]  exp_r;
    logic [15:0] result_r;

    logic [ADDR_W-1:0] mem_addr_s;
    logic              mem_we_s;
    logic [7:0]        mem_wdata_s;
    logic [7:0]        mem_rdata_s;

    logic [14:0] neg_mag_s;
    logic        is_zero_s;
    logic        is_min_s;
    logic [10:0] sig_s;
    logic        round_inc_s;
    logic [11:0] sig_sum_s;
    logic [15:0] round_word_s;

    data_mem #(
        .DEPTH  (MEM_DEPTH),
        .ADDR_W (ADDR_W)
    ) dm1 (
        .clk   (clk),
        .we    (mem_we_s),
        .addr  (mem_addr_s),
        .wdata (mem_wdata_s),
        .rdata (mem_rdata_s)
    );

    // Operand classification and magnitude; the low 15 bits of the negation
    // are exact for every negative input except 0x8000, which is special-cased
    always_comb begin
        is_zero_s = (operand_r == 16'h0000);
        is_min_s  = (operand_r == 16'h8000);
        if (operand_r[15]) begin
            neg_mag_s = ~operand_r[14:0] + 15'd1;
        end else begin
            neg_mag_s = operand_r[14:0];
        end
    end

    // Round-to-nearest-even on the normalised magnitude (leading one at bit 14)
    always_comb begin
        sig_s       = mag_r[14:4];
        round_inc_s = mag_r[3] & (mag_r[4] | (|mag_r[2:0]));
        sig_sum_s   = {1'b0, sig_s} + {11'd0, round_inc_s};
        if (sig_sum_s[11]) begin
            round_word_s = {sign_r, exp_r + 5'd1, sig_sum_s[10:1]};
        end else begin
            round_word_s = {sign_r, exp_r, sig_sum_s[9:0]};
        end
    end

    // Next-state logic; start high aborts from any state
    always_comb begin
        state_nxt_s = state_r;
        if (start) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_d_r) begin
                        state_nxt_s = LD_LO;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                LD_LO: state_nxt_s = LD_HI;
                LD_HI: state_nxt_s = NEG;
                NEG: begin
                    if (is_zero_s || is_min_s) begin
                        state_nxt_s = ST_LO;
                    end else if (neg_mag_s[14]) begin
                        state_nxt_s = ROUND;
                    end else begin
                        state_nxt_s = NORM;
                    end
                end
                NORM: begin
                    if (mag_r[13]) begin
                        state_nxt_s = ROUND;
                    end else begin
                        state_nxt_s = NORM;
                    end
                end
                ROUND:   state_nxt_s = ST_LO;
                ST_LO:   state_nxt_s = ST_HI;
                ST_HI:   state_nxt_s = DONE;
                DONE:    state_nxt_s = DONE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // Memory port steering: reads in the load states, writes in the store states
    always_comb begin
        mem_addr_s  = ADDR_W'(ADDR_IN_LO);
        mem_we_s    = 1'b0;
        mem_wdata_s = 8'd0;
        case (state_r)
            LD_HI: begin
                mem_addr_s = ADDR_W'(ADDR_IN_HI);
            end
            ST_LO: begin
                mem_addr_s  = ADDR_W'(ADDR_OUT_LO);
                mem_we_s    = ~start;
                mem_wdata_s = result_r[7:0];
            end
            ST_HI: begin
                mem_addr_s  = ADDR_W'(ADDR_OUT_HI);
                mem_we_s    = ~start;
                mem_wdata_s = result_r[15:8];
            end
            default: begin
                mem_addr_s  = ADDR_W'(ADDR_IN_LO);
                mem_we_s    = 1'b0;
                mem_wdata_s = 8'd0;
            end
        endcase
    end

    // State, start-edge history and done flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            start_d_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            start_d_r <= start;
            done_r    <= (state_nxt_s == DONE);
        end
    end

    // Conversion datapath registers, advanced by the current state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            operand_r <= 16'd0;
            sign_r    <= 1'b0;
            mag_r     <= 15'd0;
            exp_r     <= 5'd0;
            result_r  <= 16'd0;
        end else begin
            case (state_r)
                LD_LO: operand_r[7:0]  <= mem_rdata_s;
                LD_HI: operand_r[15:8] <= mem_rdata_s;
                NEG: begin
                    sign_r <= operand_r[15];
                    mag_r  <= neg_mag_s;
                    exp_r  <= EXP_TOP;
                    if (is_zero_s) begin
                        result_r <= 16'h0000;
                    end else if (is_min_s) begin
                        result_r <= MIN_INT_WORD;
                    end else begin
                        result_r <= result_r;
                    end
                end
                NORM: begin
                    mag_r <= {mag_r[13:0], 1'b0};
                    exp_r <= exp_r - 5'd1;
                end
                ROUND:   result_r <= round_word_s;
                default: result_r <= result_r;
            endcase
        end
    end

    // done is suppressed combinationally the moment start rises
    assign done = done_r & ~start;

endmodule

// File: tb/tb_int_to_float.sv
// Directed-vector bench for int_to_float: conversions, handshake, reset abort.
module tb_int_to_float;
    import int_to_float_pkg::*;

    logic clk;
    logic reset;
    logic start;
    logic done;

    int n_vec;
    int n_bad;

    int_to_float dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [15:0] val);
        dut.dm1.core[0] = val[7:0];
        dut.dm1.core[1] = val[15:8];
    endtask

    task automatic convert(input logic [15:0] val, input logic [15:0] exp, input string tag);
        int cyc;
        logic [15:0] res;
        @(negedge clk);
        preload(val);
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check({tag, "_done_low"}, {15'd0, done}, 16'd0);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency_ok"}, {15'd0, (done && cyc <= 21)}, 16'd1);
        res = {dut.dm1.core[3], dut.dm1.core[2]};
        check(tag, res, exp);
        repeat (3) @(negedge clk);
        check({tag, "_done_held"}, {15'd0, done}, 16'd1);
    endtask

    initial begin
        logic [7:0] pattern [10];
        int cyc;
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pattern[i] = 8'(i * 7 + 3);
            dut.dm1.core[i + 4] = pattern[i];
        end
        repeat (2) @(negedge clk);
        check("reset_done", {15'd0, done}, 16'd0);
        check("reset_state", 16'(dut.state_r), 16'(IDLE));
        reset = 1'b0;
        @(negedge clk);

        convert(16'h0001, 16'h3C00, "one");
        convert(16'h0002, 16'h4000, "two");
        convert(16'h0003, 16'h4200, "three");
        convert(16'h000C, 16'h4A00, "twelve");
        convert(16'h0030, 16'h5200, "fortyeight");
        convert(16'h0000, 16'h0000, "zero");
        convert(16'h8000, 16'hF800, "min_int");
        convert(16'hFFC0, 16'hD400, "neg64");
        convert(16'h1002, 16'h6C00, "tie_even");
        convert(16'h1006, 16'h6C02, "tie_odd");
        convert(16'h7FF0, 16'h77FF, "guard0");
        convert(16'h0FFF, 16'h6C00, "carry_0fff");
        convert(16'h7FFF, 16'h7800, "carry_7fff");

        for (int i = 0; i < 10; i++) begin
            check($sformatf("untouched_%0d", i + 4), {8'd0, dut.dm1.core[i + 4]}, {8'd0, pattern[i]});
        end

        // Abort by reset in the middle of normalisation (input 1 normalises longest)
        @(negedge clk);
        preload(16'h0001);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (dut.state_r != NORM && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("reached_norm", 16'(dut.state_r), 16'(NORM));
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_done", {15'd0, done}, 16'd0);
        check("abort_state", 16'(dut.state_r), 16'(IDLE));
        @(negedge clk);
        reset = 1'b0;

        convert(16'h0550, 16'h6550, "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
